// File: rtl/adsr_voice_scheduler.sv
// Round-robin scheduler that shares N_VOICES adsr voices between N_REQ note requesters.
// Define ADSR_VOICE_STEAL_EN to retrigger the least-remaining busy voice when none is free.
module adsr_voice_scheduler #(
  parameter int N_REQ    = 4,
  parameter int N_VOICES = 2,
  parameter int VW       = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [N_REQ-1:0]    i_req,
  output logic [N_REQ-1:0]    o_ack,
  output logic [VW-1:0]       o_ack_voice,
  output logic [N_VOICES-1:0] o_start,
  output logic [N_VOICES-1:0] o_busy,
  input  logic [31:0]         i_note_len,
  input  logic                i_flush
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]    ptr;
  logic [31:0]      cnt      [N_VOICES];
  logic [31:0]      cnt_next [N_VOICES];
  logic [N_REQ-1:0] eligible;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic             free_found;
  logic [VW-1:0]    free_idx;
  logic             voice_found;
  logic [VW-1:0]    voice_idx;
  logic             grant;
  logic [31:0]      load_val;

  // The requester acked this cycle is masked so a held level is not granted twice.
  assign eligible = i_req & ~o_ack;
  assign load_val = (i_note_len == 32'd0) ? 32'd1 : i_note_len;

  always_comb begin
    int      pos;
    logic [PW-1:0] pos_idx;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    pos_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_idx = PW'(pos);
      if (!win_found && eligible[pos_idx]) begin
        win_found = 1'b1;
        win_idx   = pos_idx;
      end
    end
  end

  // Scan from the top so the lowest free index is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = N_VOICES - 1; v >= 0; v--) begin
      if (cnt[v] == 32'd0) begin
        free_found = 1'b1;
        free_idx   = VW'(v);
      end
    end
  end

`ifdef ADSR_VOICE_STEAL_EN
  logic [VW-1:0] steal_idx;
  logic [31:0]   steal_min;

  // Strict less-than keeps ties on the lowest index.
  always_comb begin
    steal_idx = '0;
    steal_min = cnt[0];
    for (int v = 1; v < N_VOICES; v++) begin
      if (cnt[v] < steal_min) begin
        steal_min = cnt[v];
        steal_idx = VW'(v);
      end
    end
  end

  assign voice_found = 1'b1;
  assign voice_idx   = free_found ? free_idx : steal_idx;
`else
  assign voice_found = free_found;
  assign voice_idx   = free_idx;
`endif

  assign grant = win_found && voice_found && !i_flush;

  always_comb begin
    for (int v = 0; v < N_VOICES; v++) begin
      cnt_next[v] = cnt[v];
      if (i_flush) begin
        cnt_next[v] = 32'd0;
      end else if (grant && (voice_idx == VW'(v))) begin
        cnt_next[v] = load_val;
      end else if (cnt[v] != 32'd0) begin
        cnt_next[v] = cnt[v] - 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr         <= '0;
      o_ack       <= '0;
      o_ack_voice <= '0;
      o_start     <= '0;
      o_busy      <= '0;
      for (int v = 0; v < N_VOICES; v++) cnt[v] <= 32'd0;
    end else begin
      for (int v = 0; v < N_VOICES; v++) begin
        cnt[v]    <= cnt_next[v];
        o_busy[v] <= (cnt_next[v] != 32'd0);
      end
      if (grant) begin
        o_ack       <= N_REQ'(1) << win_idx;
        o_ack_voice <= voice_idx;
        o_start     <= N_VOICES'(1) << voice_idx;
        ptr         <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
      end else begin
        o_ack       <= '0;
        o_ack_voice <= '0;
        o_start     <= '0;
      end
    end
  end

endmodule

// File: doc/adsr_voice_scheduler.md
Name: adsr_voice_scheduler

Overview:
- Shares a pool of N_VOICES adsr envelope voices between N_REQ note requesters.
- Round-robin arbitration across requesters; lowest-index free voice is allocated.
- Issues a one-cycle start pulse to the chosen voice and tracks each voice's busy time with a per-voice down-counter.
- Sits between the note sources (MMIO/sequencer cores) and the bank of adsr voices whose o_env outputs are mixed downstream.

Parameters:
- N_REQ, 4: number of requesters; valid range 2..8.
- N_VOICES, 2: number of adsr voices; valid range 1..8.
- VW, 3: width of voice index; must satisfy 2**VW >= N_VOICES.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_req  in  N_REQ  per-requester note request; level, held until acked
- o_ack  out  N_REQ  one-cycle grant pulse to the winning requester
- o_ack_voice  out  VW  voice index allocated; valid only while any o_ack bit is 1
- o_start  out  N_VOICES  one-cycle start pulse to the allocated voice's adsr i_start
- o_busy  out  N_VOICES  voice counter nonzero
- i_note_len  in  32  note duration in clk cycles, sampled at allocation; 0 treated as 1
- i_flush  in  1  synchronous clear of all voice counters

Behaviour:
- Reset: o_ack=0, o_ack_voice=0, o_start=0, o_busy=0, all voice counters=0, round-robin pointer=0. Reset may assert at any time, including mid-note. Every output clears immediately (asynchronously).
- Per-voice counter (32 bit):
  - Loaded with max(i_note_len,1) on allocation.
  - Otherwise decrements by 1 while nonzero.
  - o_busy[v] = (counter[v] != 0), registered.
  - A voice whose counter is 1 at cycle t reads 0 at t+1 and is allocatable from t+1. It is not allocatable at t.
- Arbitration, evaluated every cycle on registered state:
  - Eligible requesters = i_req & ~o_ack. The bit acked in the current cycle is masked, so a held request is never granted twice.
  - Winner = first eligible index at or after the pointer, wrapping modulo N_REQ.
  - A grant happens only if the winner exists and a voice is available (free, or stealable when the optional feature is on).
- Grant at cycle t (all outputs registered, so latency req-to-ack is 1 cycle minimum):
  - At t+1: o_ack[winner]=1, o_ack_voice=v, o_start[v]=1, counter[v] loaded, pointer=winner+1 mod N_REQ.
  - At most one grant per cycle. Pointer is unchanged when there is no grant.
- Voice choice: lowest-index voice with counter==0.
- No voice available: the request stays pending. No ack, pointer unchanged, and o_ack/o_start are 0 for that cycle.
- Requester contract:
  - Requester drops i_req in the cycle after seeing o_ack.
  - If i_req stays high, it is treated as a new request, eligible from the cycle after ack.
- i_flush: all counters=0 next cycle. A grant in the same cycle as i_flush is suppressed (flush wins).
- i_note_len change mid-note does not affect voices already running.

Optional Feature:
- Macro: ADSR_VOICE_STEAL_EN.
- Defined:
  - When no voice is free, the voice with the smallest nonzero counter is stolen (ties go to the lowest index).
  - Stealing reloads that counter and pulses its o_start exactly like a normal allocation, so the adsr retriggers.
  - A free voice is always preferred over stealing.
- Undefined: requests wait until a voice frees. No voice is ever retriggered while busy.

Test Plan:
- Reset, then i_req=0001, i_note_len=5 -> o_ack=0001, o_ack_voice=0, o_start=01 one cycle later. o_busy[0]=1 for exactly 5 cycles, then 0.
- i_req=1111 held until each ack, note_len=100, N_VOICES=2 -> acks go to req0 then req1 on consecutive cycles, with voices 0 then 1.
  - Without steal: req2/req3 get no ack until voice 0 frees at cycle 101 after its grant. req2 is acked first.
  - With ADSR_VOICE_STEAL_EN: req2 steals voice 0 on cycle 3, and req3 steals voice 1 on cycle 4.
- Round-robin fairness: req0 and req1 continuously asserted, note_len=1, N_VOICES=2 -> grants alternate 0,1,0,1. Never two consecutive acks to the same requester.
- i_note_len=0 -> treated as 1: o_busy high for exactly 1 cycle, and the voice is reallocatable on the following cycle.
- Voice busy with counter 50, assert i_flush together with a new i_req -> no ack that cycle, o_busy=0 next cycle, and the request is granted voice 0 the cycle after.
- Assert i_reset mid-note (counter 30) with i_req held -> o_busy, o_ack, o_start drop to 0 immediately. After release, the first grant returns voice 0 with the pointer starting at requester 0.
